// File: rtl/byteswap_arbiter.sv
// Two-requester round-robin arbiter feeding one registered 32-bit byte-reversal stage.
// Define BYTESWAP_HALFWORD_EN to add per-requester mode ports (mode 1 = swap bytes within halfwords).
//
// last_grant | meaning
// 0          | req0 took the last accepted word; req1 wins the next contention
// 1          | req1 took the last accepted word (reset); req0 wins the next contention
module byteswap_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [31:0]      req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [31:0]      req1_data,
   output logic             req1_ready,
`ifdef BYTESWAP_HALFWORD_EN
   input  logic             req0_mode,
   input  logic             req1_mode,
`endif
   output logic             out_valid,
   output logic [31:0]      out_data,
   output logic             out_src,
   input  logic             out_ready,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   logic        last_grant;
   logic        grant0;
   logic        grant1;
   logic        can_accept;
   logic        acc0;
   logic        acc1;
   logic [31:0] sel_data;
   logic        sel_mode;
   logic [31:0] swapped;

   // Grants depend only on valids and the pointer, never on data.
   assign grant0     = req0_valid & (~req1_valid | last_grant);
   assign grant1     = req1_valid & (~req0_valid | ~last_grant);
   assign can_accept = ~out_valid | out_ready;
   assign req0_ready = can_accept & grant0;
   assign req1_ready = can_accept & grant1;
   assign acc0       = req0_valid & req0_ready;
   assign acc1       = req1_valid & req1_ready;

   assign sel_data = grant1 ? req1_data : req0_data;

`ifdef BYTESWAP_HALFWORD_EN
   assign sel_mode = grant1 ? req1_mode : req0_mode;
`else
   assign sel_mode = 1'b0;
`endif

   always_comb begin
      swapped = {sel_data[7:0], sel_data[15:8], sel_data[23:16], sel_data[31:24]};
      if (sel_mode)
         swapped = {sel_data[23:16], sel_data[31:24], sel_data[7:0], sel_data[15:8]};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_data   <= 32'h0;
         out_src    <= 1'b0;
         last_grant <= 1'b1;
         cnt0       <= '0;
         cnt1       <= '0;
      end else if (acc0 | acc1) begin
         out_valid  <= 1'b1;
         out_data   <= swapped;
         out_src    <= acc1;
         last_grant <= acc1;
         if (acc0)
            cnt0 <= cnt0 + 1'b1;
         if (acc1)
            cnt1 <= cnt1 + 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
